// File: rtl/cu_pkg.sv
// cu_pkg: shared types and constants for the multi-cycle RV32I control unit.
//   state_t     - FSM state encoding (TRAP only exists when CU_TRAP_EN is defined)
//   OPC_*       - base opcodes recognised by the decoder
//   RD_*        - writeback source encodings driven on rd_sel
//   F3_*        - branch condition func3 values
//   insn_cls_t  - one-hot instruction class produced by cu_op_decoder
package cu_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5
`ifdef CU_TRAP_EN
      ,S_TRAP  = 3'd6
`endif
   } state_t;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [1:0] RD_ALU = 2'd0;
   localparam logic [1:0] RD_MEM = 2'd1;
   localparam logic [1:0] RD_PC4 = 2'd2;
   localparam logic [1:0] RD_IMM = 2'd3;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef struct packed {
      logic lui;
      logic auipc;
      logic jal;
      logic jalr;
      logic branch;
      logic load;
      logic store;
      logic opimm;
      logic op;
   } insn_cls_t;

endpackage

// File: rtl/cu_multicycle_if.sv
// cu_multicycle_if: unified memory port between the control unit and memory.
//   mem_req/mem_we/addr_sel - request, store qualifier, address source (0 PC, 1 ALU)
//   mem_sz/mem_sx           - access size and sign-extension fields of the instruction
//   mem_ready               - memory completes the current request this cycle
//   wait_cnt                - stall cycles seen by the current request (debug)
// master: control unit side. slave: memory side.
interface cu_multicycle_if #(
   parameter int WAIT_W = 4
);
   logic              mem_req;
   logic              mem_we;
   logic              addr_sel;
   logic [1:0]        mem_sz;
   logic [2:0]        mem_sx;
   logic              mem_ready;
   logic [WAIT_W-1:0] wait_cnt;

   modport master (
      output mem_req, mem_we, addr_sel, mem_sz, mem_sx, wait_cnt,
      input  mem_ready
   );

   modport slave (
      input  mem_req, mem_we, addr_sel, mem_sz, mem_sx, wait_cnt,
      output mem_ready
   );
endinterface

// File: rtl/cu_op_decoder.sv
// cu_op_decoder: combinational opcode classifier.
//   opcode  in  7 : INSN[6:0]
//   cls     out   : one-hot instruction class (all zero for unknown opcodes)
//   illegal out 1 : opcode is not one of the supported RV32I base opcodes
module cu_op_decoder
   import cu_pkg::*;
(
   input  logic [6:0] opcode,
   output insn_cls_t  cls,
   output logic       illegal
);

   always_comb begin
      cls     = '0;
      illegal = 1'b0;
      case (opcode)
         OPC_LUI:    cls.lui    = 1'b1;
         OPC_AUIPC:  cls.auipc  = 1'b1;
         OPC_JAL:    cls.jal    = 1'b1;
         OPC_JALR:   cls.jalr   = 1'b1;
         OPC_BRANCH: cls.branch = 1'b1;
         OPC_LOAD:   cls.load   = 1'b1;
         OPC_STORE:  cls.store  = 1'b1;
         OPC_OPIMM:  cls.opimm  = 1'b1;
         OPC_OP:     cls.op     = 1'b1;
         default:    illegal    = 1'b1;
      endcase
   end

endmodule

// File: rtl/cu_multicycle.sv
// cu_multicycle: multi-cycle RV32I control unit (IDLE, FETCH, DECODE, EXEC, MEM, WB).
// Single free-running clock; the datapath is advanced with one-cycle load strobes.
//   CLK, RST (sync, active high)
//   INSN             - instruction register, valid from DECODE onward
//   EQ/LS/LU         - ALU compare flags, sampled at the end of EXEC
//   mem              - memory handshake port (cu_multicycle_if.master)
//   pc_en/insn_en/rd_en, pc_next_sel, ALU controls, rd_sel, register fields, state
//   trap             - sticky fault flag, only with CU_TRAP_EN
// Macro CU_TRAP_EN: adds TRAP state (illegal opcode or memory wait timeout).
// Without it illegal opcodes retire as NOPs and memory waits are unbounded.
module cu_multicycle
   import cu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int WAIT_W = 4
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [XLEN-1:0] INSN,
   input  logic            EQ,
   input  logic            LS,
   input  logic            LU,
   cu_multicycle_if.master mem,
   output logic            pc_en,
   output logic            insn_en,
   output logic            rd_en,
   output logic            pc_next_sel,
   output logic            pc_alu_sel,
   output logic            sub_sra,
   output logic            alu_sel_a,
   output logic            alu_sel_b,
   output logic [2:0]      func3,
   output logic [1:0]      rd_sel,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic [2:0]      state
`ifdef CU_TRAP_EN
   ,output logic           trap
`endif
);

   localparam logic [WAIT_W-1:0] CNT_MAX  = '1;
   localparam logic [WAIT_W-1:0] CNT_LAST = CNT_MAX ^ WAIT_W'(1);

   state_t            st, st_n;
   logic [WAIT_W-1:0] cnt;
   logic              taken, taken_d;
   logic              active, wr_rd, stall, illegal;
   insn_cls_t         cls;
   logic [2:0]        f3;
   logic              unused_insn;

   // Encoding is fixed 32-bit; bits only consumed by the immediate path are sunk here.
   assign unused_insn = ^{INSN[XLEN-1:31], INSN[29:25]};
   assign f3          = INSN[14:12];

   cu_op_decoder u_dec (
      .opcode  (INSN[6:0]),
      .cls     (cls),
      .illegal (illegal)
   );

   assign rs1             = INSN[19:15];
   assign rs2             = INSN[24:20];
   assign rd              = INSN[11:7];
   assign mem.mem_sz      = INSN[13:12];
   assign mem.mem_sx      = INSN[14:12];
   assign mem.wait_cnt    = cnt;
   assign state           = st;
`ifdef CU_TRAP_EN
   assign trap            = (st == S_TRAP);
`endif

   assign active = (st == S_DECODE) || (st == S_EXEC) || (st == S_MEM) || (st == S_WB);
   assign stall  = ((st == S_FETCH) || (st == S_MEM)) && !mem.mem_ready;
   assign wr_rd  = !illegal && (rd != 5'd0) &&
                   (cls.lui | cls.auipc | cls.jal | cls.jalr | cls.load | cls.opimm | cls.op);

   always_comb begin
      taken_d = cls.jal | cls.jalr;
      if (cls.branch) begin
         case (f3)
            F3_BEQ:  taken_d = EQ;
            F3_BNE:  taken_d = ~EQ;
            F3_BLT:  taken_d = LS;
            F3_BGE:  taken_d = ~LS;
            F3_BLTU: taken_d = LU;
            F3_BGEU: taken_d = ~LU;
            default: taken_d = 1'b0;
         endcase
      end
   end

   // Decoded ALU/writeback controls; held at zero while no instruction is in flight.
   // Branches use the ALU for PC+imm (flags come from the compare unit), hence add.
   always_comb begin
      alu_sel_a  = 1'b0;
      alu_sel_b  = 1'b0;
      pc_alu_sel = 1'b0;
      sub_sra    = 1'b0;
      func3      = 3'b000;
      rd_sel     = RD_ALU;
      if (active) begin
         alu_sel_a  = cls.auipc | cls.jal | cls.branch;
         alu_sel_b  = (|cls) & ~cls.op;
         pc_alu_sel = cls.jal | cls.jalr | cls.branch;
         sub_sra    = INSN[30] & (cls.op | (cls.opimm & (f3 == 3'b101)));
         func3      = (cls.op | cls.opimm) ? f3 : 3'b000;
         if (cls.load)                rd_sel = RD_MEM;
         else if (cls.jal | cls.jalr) rd_sel = RD_PC4;
         else if (cls.lui)            rd_sel = RD_IMM;
      end
   end

   always_comb begin
      st_n         = st;
      mem.mem_req  = 1'b0;
      mem.mem_we   = 1'b0;
      mem.addr_sel = 1'b0;
      insn_en      = 1'b0;
      pc_en        = 1'b0;
      rd_en        = 1'b0;
      pc_next_sel  = 1'b0;
      case (st)
         S_IDLE: st_n = S_FETCH;
         S_FETCH: begin
            mem.mem_req = 1'b1;
            if (mem.mem_ready) begin
               insn_en = 1'b1;
               st_n    = S_DECODE;
            end
`ifdef CU_TRAP_EN
            else if (cnt == CNT_LAST) st_n = S_TRAP;
`endif
         end
         S_DECODE: begin
`ifdef CU_TRAP_EN
            st_n = illegal ? S_TRAP : S_EXEC;
`else
            st_n = S_EXEC;
`endif
         end
         S_EXEC: st_n = (cls.load | cls.store) ? S_MEM : S_WB;
         S_MEM: begin
            mem.mem_req  = 1'b1;
            mem.addr_sel = 1'b1;
            mem.mem_we   = cls.store;
            if (mem.mem_ready) st_n = S_WB;
`ifdef CU_TRAP_EN
            else if (cnt == CNT_LAST) st_n = S_TRAP;
`endif
         end
         S_WB: begin
            pc_en       = 1'b1;
            pc_next_sel = taken;
            rd_en       = wr_rd;
            st_n        = S_FETCH;
         end
`ifdef CU_TRAP_EN
         S_TRAP: st_n = S_TRAP;
`endif
         default: st_n = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         st    <= S_IDLE;
         taken <= 1'b0;
         cnt   <= '0;
      end else begin
         st <= st_n;
         if (st == S_EXEC) taken <= taken_d;
         // Fresh count per memory request; saturate so a long stall never looks short.
         if ((st_n != st) && ((st_n == S_FETCH) || (st_n == S_MEM))) cnt <= '0;
         else if (stall && (cnt != CNT_MAX))                         cnt <= cnt + WAIT_W'(1);
      end
   end

endmodule
